// File: rtl/ram_ctrl.sv
// ram_ctrl: asynchronous SRAM controller locked to the mem_bridge four-phase
// ramState sequence. One request is latched per phase cycle; strobes, the
// tri-state data enable and read data are all registered.
// Optional feature macro: RAM_PHASE_CHECK_EN (sticky phase-sequence error flag).
module ram_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ramState_i,
  input  logic [15:0]       memAddress_i,
  input  logic [DATA_W-1:0] memDataWrite_i,
  input  logic              memReadWrite_i,
  input  logic              memEnable_i,
  output logic [DATA_W-1:0] memDataRead_o,
  output logic              ack_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_data_oe_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic              phase_err_o
);

  // Phase encoding from the bridge (Gray sequence ONE->TWO->THREE->FOUR).
  localparam logic [1:0] PH_ONE   = 2'b00;
  localparam logic [1:0] PH_TWO   = 2'b01;
  localparam logic [1:0] PH_THREE = 2'b11;
  localparam logic [1:0] PH_FOUR  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_STROBE2 = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Decoded events from the next-state logic, consumed by the output logic.
  logic start_s;    // latch a new request (from IDLE or back-to-back from HOLD)
  logic release_s;  // orderly bus release after a completed access
  logic abort_s;    // phase sequence broken mid-access

  // Registered outputs and request context.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              data_oe_q, data_oe_d;
  logic              ack_q, ack_d;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each state expects exactly one phase; anything else aborts.
  always_comb begin
    state_d   = state_q;
    start_s   = 1'b0;
    release_s = 1'b0;
    abort_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((ramState_i == PH_ONE) && memEnable_i) begin
          start_s = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (ramState_i == PH_TWO) begin
          state_d = ST_STROBE;
        end else begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (ramState_i == PH_THREE) begin
          state_d = ST_STROBE2;
        end else begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_STROBE2: begin
        if (ramState_i == PH_FOUR) begin
          state_d = ST_HOLD;
        end else begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        case (ramState_i)
          PH_ONE: begin
            if (memEnable_i) begin
              start_s = 1'b1;
              state_d = ST_SETUP;
            end else begin
              release_s = 1'b1;
              state_d   = ST_IDLE;
            end
          end
          PH_FOUR: begin
            // Bridge stalled (e.g. flash read): release quietly, not an error.
            release_s = 1'b1;
            state_d   = ST_IDLE;
          end
          default: begin
            abort_s = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
      end
      default: begin
        release_s = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of every registered SRAM-side and bridge-side output.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    data_oe_d = data_oe_q;
    ack_d     = 1'b0;
    if (start_s) begin
      addr_d    = {{(ADDR_W-16){1'b0}}, memAddress_i};
      rw_d      = memReadWrite_i;
      ce_n_d    = 1'b0;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      // A read must never leave our drivers on while the SRAM drives the bus.
      data_oe_d = memReadWrite_i;
      if (memReadWrite_i) begin
        wdata_d = memDataWrite_i;
      end else begin
        wdata_d = wdata_q;
      end
    end else if (release_s || abort_s) begin
      ce_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      data_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_SETUP: begin
          // Phase TWO: open the strobe for the latched direction.
          if (rw_q) begin
            we_n_d = 1'b0;
          end else begin
            oe_n_d = 1'b0;
          end
        end
        ST_STROBE2: begin
          // Phase FOUR: close the strobe, capture read data, signal completion.
          if (!rw_q) begin
            rdata_d = ram_data_i;
          end else begin
            rdata_d = rdata_q;
          end
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          ack_d  = 1'b1;
        end
        default: begin
          ack_d = 1'b0;
        end
      endcase
    end
  end

  // Output registers; reset releases the SRAM bus asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      rw_q      <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
    end
  end

`ifdef RAM_PHASE_CHECK_EN
  logic phase_err_q, phase_err_d;

  // Sticky phase error: any abort sets it, only reset clears it.
  always_comb begin
    if (abort_s) begin
      phase_err_d = 1'b1;
    end else begin
      phase_err_d = phase_err_q;
    end
  end

  // Phase error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_err_q <= 1'b0;
    end else begin
      phase_err_q <= phase_err_d;
    end
  end

  assign phase_err_o = phase_err_q;
`else
  assign phase_err_o = 1'b0;
`endif

  assign memDataRead_o = rdata_q;
  assign ack_o         = ack_q;
  assign ram_addr_o    = addr_q;
  assign ram_data_o    = wdata_q;
  assign ram_data_oe_o = data_oe_q;
  assign ram_ce_n_o    = ce_n_q;
  assign ram_oe_n_o    = oe_n_q;
  assign ram_we_n_o    = we_n_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed testbench for ram_ctrl with a small behavioural SRAM model.
module tb_ram_ctrl;

  localparam logic [1:0] ONE   = 2'b00;
  localparam logic [1:0] TWO   = 2'b01;
  localparam logic [1:0] THREE = 2'b11;
  localparam logic [1:0] FOUR  = 2'b10;

`ifdef RAM_PHASE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ramState = 2'b00;
  logic [15:0] memAddress = 16'h0000;
  logic [15:0] memDataWrite = 16'h0000;
  logic        memReadWrite = 1'b0;
  logic        memEnable = 1'b0;
  logic [15:0] memDataRead;
  logic        ack;
  logic [17:0] ram_addr;
  logic [15:0] ram_data_out;
  logic        ram_data_oe;
  logic [15:0] ram_data_in;
  logic        ce_n, oe_n, we_n, phase_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] sram [0:255];

  ram_ctrl #(.ADDR_W(18), .DATA_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .ramState_i    (ramState),
    .memAddress_i  (memAddress),
    .memDataWrite_i(memDataWrite),
    .memReadWrite_i(memReadWrite),
    .memEnable_i   (memEnable),
    .memDataRead_o (memDataRead),
    .ack_o         (ack),
    .ram_addr_o    (ram_addr),
    .ram_data_o    (ram_data_out),
    .ram_data_oe_o (ram_data_oe),
    .ram_data_i    (ram_data_in),
    .ram_ce_n_o    (ce_n),
    .ram_oe_n_o    (oe_n),
    .ram_we_n_o    (we_n),
    .phase_err_o   (phase_err)
  );

  always #5 clk = ~clk;

  // SRAM model: word written on each clock while selected with we_n low.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
      sram[5] <= 16'h5A5A;
    end else if (!ce_n && !we_n) begin
      sram[ram_addr[7:0]] <= ram_data_out;
    end
  end

  assign ram_data_in = (!ce_n && !oe_n) ? sram[ram_addr[7:0]] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one phase between edges, then return just after the sampling edge.
  task automatic cyc(input logic [1:0] ph, input logic en, input logic rw,
                     input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ramState = ph; memEnable = en; memReadWrite = rw;
    memAddress = a; memDataWrite = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] ph);
    cyc(ph, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rdata", {16'h0, memDataRead}, 32'h0);
    chk("rst_strobes", {29'h0, ce_n, oe_n, we_n}, 32'h7);
    chk("rst_misc", {14'h0, ram_addr, 1'b0, ack}, 32'h0);
    chk("rst_data", {15'h0, ram_data_oe, ram_data_out}, 32'h0);
    chk("rst_err", {31'h0, phase_err}, 32'h0);
    @(negedge clk); rst = 1'b1;
    idle(FOUR);

    // Write 0xBEEF to 0x1234
    cyc(ONE, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
    chk("wr_k_addr", {14'h0, ram_addr}, 32'h01234);
    chk("wr_k_strb", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'h7);  // ce0 oe1 we1 doe1
    chk("wr_k_data", {16'h0, ram_data_out}, 32'hBEEF);
    idle(TWO);
    chk("wr_k1_we", {29'h0, ce_n, oe_n, we_n}, 32'h2);
    idle(THREE);
    chk("wr_k2_we", {29'h0, ce_n, oe_n, we_n}, 32'h2);
    chk("wr_k2_ack", {31'h0, ack}, 32'h0);
    idle(FOUR);
    chk("wr_k3_strb", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'h7);
    chk("wr_k3_ack", {31'h0, ack}, 32'h1);
    idle(ONE);
    chk("wr_rel", {28'h0, ce_n, ram_data_oe, ack, we_n}, 32'h9);
    chk("wr_mem", {16'h0, sram[8'h34]}, 32'hBEEF);

    // Read 0x0005, SRAM returns 0x5A5A
    cyc(ONE, 1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("rd_k", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'h6);
    chk("rd_k_addr", {14'h0, ram_addr}, 32'h00005);
    idle(TWO);
    chk("rd_k1", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'h2);
    idle(THREE);
    chk("rd_k2", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'h2);
    idle(FOUR);
    chk("rd_k3", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'h6);
    chk("rd_k3_data", {15'h0, ack, memDataRead}, 32'h15A5A);
    idle(ONE);
    chk("rd_rel", {15'h0, ce_n, memDataRead}, 32'h15A5A);

    // Back-to-back write 0x0001 -> 0x0010, then read 0x0010
    cyc(ONE, 1'b1, 1'b1, 16'h0010, 16'h0001);
    idle(TWO); idle(THREE); idle(FOUR);
    chk("b2b_ack1", {31'h0, ack}, 32'h1);
    cyc(ONE, 1'b1, 1'b0, 16'h0010, 16'hFFFF);
    chk("b2b_bound", {27'h0, ce_n, oe_n, we_n, ram_data_oe, ack}, 32'h0C);
    idle(TWO);
    chk("b2b_oe", {28'h0, oe_n, we_n, ram_data_oe, ack}, 32'h4);
    idle(THREE);
    chk("b2b_noack", {31'h0, ack}, 32'h0);
    idle(FOUR);
    chk("b2b_rd", {15'h0, ack, memDataRead}, 32'h10001);

    // Boot stall: FOUR held after a completed write
    idle(ONE);
    cyc(ONE, 1'b1, 1'b1, 16'h0040, 16'h1111);
    idle(TWO); idle(THREE); idle(FOUR);
    chk("stall_ack", {31'h0, ack}, 32'h1);
    idle(FOUR);
    chk("stall_rel", {29'h0, ce_n, ram_data_oe, ack}, 32'h4);
    for (int i = 0; i < 15; i++) idle(FOUR);
    chk("stall_end", {28'h0, ce_n, ram_data_oe, ack, phase_err}, 32'h8);
    chk("stall_rdata", {16'h0, memDataRead}, 32'h0001);

    // Phase jump ONE -> THREE after a request is sampled
    cyc(ONE, 1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("jmp_k", {31'h0, ce_n}, 32'h0);
    idle(THREE);
    chk("jmp_abort", {27'h0, ce_n, oe_n, we_n, ram_data_oe, ack}, 32'h1C);
    chk("jmp_err", {31'h0, phase_err}, {31'h0, ERR_EXP});
    idle(FOUR); idle(ONE);
    chk("jmp_noack", {15'h0, ack, memDataRead}, 32'h00001);
    chk("jmp_sticky", {31'h0, phase_err}, {31'h0, ERR_EXP});

    // Reset asserted while we_n is low
    cyc(ONE, 1'b1, 1'b1, 16'h0030, 16'hCAFE);
    idle(TWO);
    chk("mid_we", {31'h0, we_n}, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("mid_strb", {28'h0, ce_n, oe_n, we_n, ram_data_oe}, 32'hE);
    chk("mid_out", {14'h0, ram_addr}, 32'h0);
    chk("mid_data", {15'h0, ack, memDataRead}, 32'h0);
    chk("mid_wdata", {15'h0, phase_err, ram_data_out}, 32'h0);

    // Recovery after reset: a normal read still completes
    @(negedge clk); rst = 1'b1;
    cyc(ONE, 1'b1, 1'b0, 16'h0005, 16'h0000);
    idle(TWO); idle(THREE); idle(FOUR);
    chk("rec_rd", {15'h0, ack, memDataRead}, 32'h15A5A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Drives the board's asynchronous SRAM from the four-phase `ramState` sequence and the request bus produced by `mem_bridge`, both during flash-to-RAM boot and while the CPU runs. It latches one request per phase cycle, generates the chip-enable, output-enable and write-enable strobes plus tri-state data control, and returns registered read data to the bridge. Every access is locked to `ramState_i`, so no per-request handshake exists.

## Interface
- `ADDR_W`, 18: physical SRAM address width; the address is `{(ADDR_W-16)'b0, memAddress_i}`.
- `DATA_W`, 16: data width; must equal `MemBus` width.

Ports:
- `clk`  in  1  system clock, the full-rate clock `mem_bridge` runs on.
- `rst`  in  1  asynchronous, active-low reset.
- `ramState_i`  in  2  phase from bridge: 00 ONE, 01 TWO, 11 THREE, 10 FOUR.
- `memAddress_i`  in  16  word address.
- `memDataWrite_i`  in  DATA_W  write data.
- `memReadWrite_i`  in  1  0 = read, 1 = write.
- `memEnable_i`  in  1  request valid; sampled only in phase ONE.
- `memDataRead_o`  out  DATA_W  registered read data.
- `ack_o`  out  1  one-cycle pulse when an access completes.
- `ram_addr_o`  out  ADDR_W  SRAM address.
- `ram_data_o`  out  DATA_W  SRAM write data.
- `ram_data_oe_o`  out  1  1 = drive the data bus (top-level tri-state).
- `ram_data_i`  in  DATA_W  SRAM data bus input.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1 each  active-low strobes.
- `phase_err_o`  out  1  sticky phase-sequence error (see Configuration).

## Operation
- FSM states: IDLE, SETUP, STROBE, STROBE2, HOLD. Each transition is taken on a `clk` rising edge, based on the sampled `ramState_i`.
- IDLE:
  - On ONE with `memEnable_i`=1: latch address, write data and rw into internal registers. Drive `ram_addr_o`; assert `ce_n`=0. For a write, also drive `ram_data_o` and set `oe`=1. Go to SETUP.
  - Any other phase or enable value: remain in IDLE.
- SETUP, on TWO: read asserts `oe_n`=0; write asserts `we_n`=0. Go to STROBE.
- STROBE, on THREE: hold all strobes. Go to STROBE2.
- STROBE2, on FOUR:
  - Read: `memDataRead_o <= ram_data_i`, `oe_n`=1.
  - Write: `we_n`=1; data and `ce_n` stay held.
  - Pulse `ack_o`; go to HOLD.
- HOLD:
  - ONE with enable: start a new request exactly as from IDLE (back-to-back; `ce_n` stays 0).
  - ONE without enable: release (`ce_n`=1, `oe`=0) and go to IDLE.
  - FOUR (bridge stalled, e.g. during a flash read): release and go to IDLE; this is not an error.
- Abort: an unexpected phase in SETUP, STROBE, STROBE2, or a TWO/THREE phase in HOLD, does the following in one edge:
  - deasserts all strobes, sets `oe`=0, sets `ce_n`=1;
  - goes to IDLE;
  - leaves `memDataRead_o` unchanged and raises no `ack_o`.
- `we_n` and `oe_n` are never low together. `ram_data_oe_o` is never 1 while `oe_n`=0.

## Timing
- Reset values:
  - `memDataRead_o`=0, `ack_o`=0, `ram_addr_o`=0, `ram_data_o`=0, `ram_data_oe_o`=0;
  - `ram_ce_n_o`=`ram_oe_n_o`=`ram_we_n_o`=1, `phase_err_o`=0;
  - FSM in IDLE.
- Reset asserted mid-access releases the bus immediately (asynchronously).
- All outputs are registered; nothing is combinational from input to output.
- Request sampled at edge k (phase ONE):
  - Strobe active from edge k+1 to edge k+3: 2 cycles of `we_n`/`oe_n` low.
  - Read data and `ack_o` valid after edge k+3.
  - Address and write data are stable for 1 cycle before and 1 cycle after the strobe.
- Throughput: one access per 4 `clk` cycles, which matches `clk_quarter`.

## Configuration
- `RAM_PHASE_CHECK_EN` defined:
  - every abort sets `phase_err_o`=1;
  - the flag stays set until `rst`.
- `RAM_PHASE_CHECK_EN` undefined:
  - `phase_err_o` is tied to 0;
  - the error register is not built;
  - abort behaviour is otherwise identical.

## Test plan
- Write 0xBEEF to address 0x1234 during ONE..FOUR. Required response:
  - `ram_addr_o`=0x01234 and `ce_n`=0 from edge k;
  - `we_n`=0 during edges k+1..k+3;
  - `ram_data_oe_o`=1 with data 0xBEEF until release;
  - `ack_o` pulses after edge k+3.
- Read address 0x0005 with SRAM model returning 0x5A5A. Required response:
  - `oe_n`=0 for 2 cycles;
  - `memDataRead_o`=0x5A5A after edge k+3;
  - `ram_data_oe_o` stays 0.
- Back-to-back: write 0x0001→0x0010, then read 0x0010. Required response:
  - `ce_n` stays low across the boundary;
  - the read returns 0x0001;
  - two `ack_o` pulses, 4 cycles apart.
- Boot stall: after a write completes, hold `ramState_i`=FOUR for 16 cycles. Required response:
  - release to IDLE with `ce_n`=1;
  - `phase_err_o` stays 0.
- Phase jump ONE→THREE after a request is sampled. Required response:
  - abort with all strobes high and no `ack_o`;
  - with `RAM_PHASE_CHECK_EN`, `phase_err_o`=1 until reset.
- Assert `rst`=0 while `we_n`=0. Required response:
  - `we_n`=`ce_n`=1 and `ram_data_oe_o`=0 before the next clock edge;
  - all outputs at their reset values.
